// File: rtl/pixel_normalizer.sv
// rtl/pixel_normalizer.sv - multi-lane fixed-point pixel normalizer with iterative reciprocal
//
// Purpose: after the crop-filter signals completion, compute coef = 2^(2*FRAC_W) / denominator
// with a restoring divider, then scale every lane of the pixel stream by coef, round half up,
// and saturate to PIXEL_W bits through a two-stage pipeline with full stream backpressure.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   ap_start, ap_done       frame start pulse (IDLE/DONE only), done pulse on tlast output handshake
//   ap_idle                 high in IDLE and DONE
//   upstream_done           crop-filter completion pulse, releases the divider
//   norm_denominator        denominator, sampled when ap_start is accepted
//   s_axis_*                input pixel stream, LANES x PIXEL_W per beat, tuser/tlast side-band
//   m_axis_*                normalized output stream
//   div_by_zero             sticky flag, cleared by the next accepted ap_start
//   sat_count               saturated lanes this frame, stops at 0xFFFF
module pixel_normalizer #(
  parameter int PIXEL_W = 16,
  parameter int FRAC_W  = 10,
  parameter int LANES   = 4,
  parameter int USER_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic                     upstream_done,
  output logic                     ap_done,
  output logic                     ap_idle,
  input  logic [PIXEL_W-1:0]       norm_denominator,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [LANES*PIXEL_W-1:0] s_axis_tdata,
  input  logic [USER_W-1:0]        s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [LANES*PIXEL_W-1:0] m_axis_tdata,
  output logic [USER_W-1:0]        m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     div_by_zero,
  output logic [15:0]              sat_count
);

  localparam int DIV_N  = 2*FRAC_W + 1;
  localparam int CNT_W  = $clog2(DIV_N);
  localparam int PROD_W = 2*PIXEL_W;
  localparam int NS_W   = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(DIV_N - 1);
  localparam logic [PIXEL_W-1:0] MAX_PIX  = '1;
  localparam logic [PROD_W-1:0]  HALF     = PROD_W'(1) << (FRAC_W - 1);
  localparam logic [PROD_W-1:0]  MAX_WIDE = {{(PROD_W-PIXEL_W){1'b0}}, MAX_PIX};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_UP = 3'd1,
    S_DIV     = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PIXEL_W-1:0] denom_q, denom_d;
  logic [PIXEL_W-1:0] coef_q, coef_d;
  logic [PIXEL_W-1:0] rem_q, rem_d;
  logic [DIV_N-2:0]   quot_q, quot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;
  logic               tlast_seen_q, tlast_seen_d;

  // Divider datapath. The numerator 2^(2*FRAC_W) has a single set bit, so the bit
  // shifted in is 1 only on the first iteration.
  logic               num_bit;
  logic [PIXEL_W:0]   rem_shift;
  logic               rem_ge;
  logic [PIXEL_W-1:0] rem_sub;
  logic [DIV_N-1:0]   quot_full;
  logic               coef_ovf;

  assign num_bit   = (cnt_q == '0);
  assign rem_shift = {rem_q, num_bit};
  assign rem_ge    = rem_shift >= {1'b0, denom_q};
  // The difference is always below denom, so the low PIXEL_W bits are exact.
  assign rem_sub   = rem_shift[PIXEL_W-1:0] - denom_q;
  assign quot_full = {quot_q, rem_ge};
  assign coef_ovf  = {{PIXEL_W{1'b0}}, quot_full} > {{DIV_N{1'b0}}, MAX_PIX};

  // Stream handshake
  logic en, s_fire, out_fire, start_ok;

  logic                     v1_q;
  logic [PROD_W-1:0]        p1_q [LANES];
  logic [USER_W-1:0]        u1_q;
  logic                     l1_q;
  logic                     m_valid_q;
  logic [LANES*PIXEL_W-1:0] m_data_q;
  logic [USER_W-1:0]        m_user_q;
  logic                     m_last_q;
  logic [15:0]              sat_q;

  assign en            = !m_valid_q || m_axis_tready;
  assign s_axis_tready = (state_q == S_STREAM) && en && !tlast_seen_q;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign out_fire      = m_valid_q && m_axis_tready;
  assign start_ok      = ap_start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d      = state_q;
    denom_d      = denom_q;
    coef_d       = coef_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    cnt_d        = cnt_q;
    dbz_d        = dbz_q;
    tlast_seen_d = tlast_seen_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (ap_start) begin
          denom_d      = norm_denominator;
          dbz_d        = 1'b0;
          tlast_seen_d = 1'b0;
          rem_d        = '0;
          quot_d       = '0;
          cnt_d        = '0;
          state_d      = upstream_done ? S_DIV : S_WAIT_UP;
        end
      end
      S_WAIT_UP: begin
        if (upstream_done) begin
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d  = rem_ge ? rem_sub : rem_shift[PIXEL_W-1:0];
        quot_d = quot_full[DIV_N-2:0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) begin
          // A zero denominator runs the full iteration count and is overridden here.
          if ((denom_q == '0) || coef_ovf) begin
            coef_d = MAX_PIX;
          end else begin
            coef_d = PIXEL_W'(quot_full);
          end
          dbz_d   = (denom_q == '0);
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (s_fire && s_axis_tlast) begin
          tlast_seen_d = 1'b1;
        end
        if (out_fire && m_last_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      denom_q      <= '0;
      coef_q       <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      cnt_q        <= '0;
      dbz_q        <= 1'b0;
      tlast_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      denom_q      <= denom_d;
      coef_q       <= coef_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      cnt_q        <= cnt_d;
      dbz_q        <= dbz_d;
      tlast_seen_q <= tlast_seen_d;
    end
  end

  // Stage 2 combinational: round half up, saturate, count saturated lanes.
  logic [PROD_W-1:0]        rnd [LANES];
  logic [LANES-1:0]         sat_vec;
  logic [LANES*PIXEL_W-1:0] sat_data;
  logic [NS_W-1:0]          nsat;
  logic [16:0]              sat_sum;
  logic [15:0]              sat_next;

  always_comb begin
    sat_data = '0;
    sat_vec  = '0;
    nsat     = '0;
    for (int i = 0; i < LANES; i++) begin
      rnd[i]     = (p1_q[i] + HALF) >> FRAC_W;
      sat_vec[i] = rnd[i] > MAX_WIDE;
      sat_data[i*PIXEL_W +: PIXEL_W] = sat_vec[i] ? MAX_PIX : rnd[i][PIXEL_W-1:0];
      nsat       = nsat + NS_W'(sat_vec[i]);
    end
    sat_sum  = {1'b0, sat_q} + 17'(nsat);
    sat_next = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q      <= 1'b0;
      u1_q      <= '0;
      l1_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        p1_q[i] <= '0;
      end
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
      sat_q     <= '0;
    end else begin
      if (en) begin
        v1_q <= s_fire;
        if (s_fire) begin
          for (int i = 0; i < LANES; i++) begin
            p1_q[i] <= PROD_W'(s_axis_tdata[i*PIXEL_W +: PIXEL_W]) * PROD_W'(coef_q);
          end
          u1_q <= s_axis_tuser;
          l1_q <= s_axis_tlast;
        end
        m_valid_q <= v1_q;
        if (v1_q) begin
          m_data_q <= sat_data;
          m_user_q <= u1_q;
          m_last_q <= l1_q;
        end
      end
      if (start_ok) begin
        sat_q <= '0;
      end else if (en && v1_q) begin
        sat_q <= sat_next;
      end
    end
  end

  assign ap_done      = (state_q == S_STREAM) && out_fire && m_last_q;
  assign ap_idle      = (state_q == S_IDLE) || (state_q == S_DONE);
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign div_by_zero   = dbz_q;
  assign sat_count     = sat_q;

endmodule

// File: doc/pixel_normalizer.md
# pixel_normalizer

Multi-lane, fixed-point pixel normalizer for the crop-filter output stream. Once the upstream crop-filter reports completion, it computes a reciprocal coefficient 1/norm_denominator with an iterative divider. It then streams LANES pixels per beat through a two-stage multiply / round / saturate pipeline with full AXI-Stream backpressure. It replaces the single-lane, combinational-multiply normalizer with a frame-controlled block that exposes ap_start/ap_done/ap_idle.

## Interface
- PIXEL_W, 16, unsigned pixel width; also the width of the denominator and the coefficient.
- FRAC_W, 10, fraction bits of the unsigned fixed-point format (1.0 = 2^FRAC_W); 2*FRAC_W+1 ≤ 2*PIXEL_W.
- LANES, 4, pixels per stream beat.
- USER_W, 2, tuser width, passed through unchanged.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  one-cycle start pulse; accepted only in IDLE or DONE.
- upstream_done  in  1  crop-filter ap_done pulse.
- ap_done  out  1  one-cycle pulse when the tlast beat is accepted at the output.
- ap_idle  out  1  high in IDLE and DONE.
- norm_denominator  in  PIXEL_W  sampled on the cycle ap_start is accepted.
- s_axis_tvalid/tready  in/out  1  input handshake.
- s_axis_tdata  in  LANES*PIXEL_W  lane i occupies bits [i*PIXEL_W +: PIXEL_W].
- s_axis_tuser  in  USER_W; s_axis_tlast  in  1.
- m_axis_tvalid/tready  out/in  1; m_axis_tdata  out  LANES*PIXEL_W; m_axis_tuser  out  USER_W; m_axis_tlast  out  1.
- div_by_zero  out  1  sticky until the next accepted ap_start.
- sat_count  out  16  count of saturated lanes this frame; stops at 0xFFFF.

## Operation
- FSM states: IDLE → WAIT_UP → DIV → STREAM → DONE.
- **IDLE/DONE:**
  - An accepted ap_start latches the denominator, clears sat_count and div_by_zero, and moves to WAIT_UP.
  - If upstream_done is high in the same cycle as ap_start, the FSM moves directly to DIV.
- **WAIT_UP:** upstream_done moves the FSM to DIV. ap_start is ignored.
- **DIV:**
  - Restoring divider, one quotient bit per cycle, N = 2*FRAC_W+1 cycles.
  - Numerator is 2^(2*FRAC_W); coef = floor(numerator / denom).
  - If coef > 2^PIXEL_W−1, coef saturates to all-ones.
  - If denom = 0: coef = all-ones, div_by_zero = 1, and the DIV cycle count is unchanged.
  - After N cycles, the FSM moves to STREAM.
- **STREAM:**
  - Per lane: p = pix*coef (2*PIXEL_W bits), then r = (p + 2^(FRAC_W−1)) >> FRAC_W (round half up).
  - If r > 2^PIXEL_W−1: output all-ones and increment sat_count once per saturated lane, up to 4 per beat.
  - tuser and tlast travel with their beat.
  - When the output beat with tlast is accepted (tvalid & tready), pulse ap_done and move to DONE.
- s_axis_tready is 0 in every state except STREAM.
- Reset behaviour:
  - All outputs reset to 0, except ap_idle = 1.
  - The FSM goes to IDLE, the pipeline is flushed and in-flight beats are discarded.
  - Reset mid-frame gets the same behaviour.

## Timing
- **Pipeline:** two registered stages, multiply → round/saturate+output register. Latency from input acceptance to output valid is 2 cycles.
- **Handshake:**
  - Stall enable en = !m_axis_tvalid | m_axis_tready.
  - s_axis_tready = (state==STREAM) & en & !tlast_seen.
  - After tlast is accepted at the input, no further input beats are taken.
- **Throughput:** 1 beat/cycle under continuous tready.
- **Data stability:** m_axis_tdata/tuser/tlast hold stable while tvalid & !tready.
- **Start-to-stream latency:** the first s_axis_tready can assert N+1 cycles after upstream_done, because DIV occupies N cycles.
- **ap_done:** asserts in the same cycle the tlast output handshake completes.
- **ap_idle:** goes high the following cycle.

## Test plan
- **Nominal normalization:** PIXEL_W=16, FRAC_W=10, LANES=4, denom 0x200 (0.5), upstream_done pulsed.
  - Expect coef 0x800 (2.0).
  - Input lanes {0x100,0x001,0x3FF,0x000} → {0x200,0x002,0x7FE,0x000}.
  - First s_axis_tready exactly 22 cycles after upstream_done.
- **Rounding:** denom 0x600 (1.5) → coef 0x2AA.
  - Pixel 0x300 → 0x200 (0x300*0x2AA = 0x7FE00, >>10 with round = 0x200).
- **Saturation:** denom 0x200, lanes {0x9000,0x8000,0x7FFF,0x10}.
  - Output {0xFFFF,0xFFFF,0xFFFE,0x20}; sat_count = 2.
- **Divide by zero:** denom 0 → div_by_zero = 1, coef 0xFFFF.
  - Pixel 0x400 → 0xFFFF; the flag clears on the next ap_start.
- **Backpressure:** random m_axis_tready (~50%) over a 64-beat frame.
  - No beat is lost or duplicated, and order is preserved.
  - tdata is stable while stalled; exactly one ap_done, on the tlast handshake.
- **Reset and ordering:**
  - Assert reset mid-stream with 2 beats in flight → outputs return to reset values, ap_idle = 1, the next frame runs cleanly.
  - ap_start in the same cycle as upstream_done skips WAIT_UP.
